// File: rtl/segment_r_responder_pkg.sv
// Shared definitions for the segment read responder: token layout, default
// widths and output queue depth.
package segment_pkg;

  localparam int SEG_AW         = 8;
  localparam int SEG_DW         = 16;
  localparam int SEG_OUTQ_DEPTH = 3;

  typedef struct packed {
    logic              e;
    logic              v;
    logic [SEG_DW-1:0] d;
  } seg_tok_t;

  // Pointer increment with wrap at the queue depth (not a power of two).
  function automatic logic [1:0] seg_wrap_inc(input logic [1:0] p);
    return (p == 2'(SEG_OUTQ_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/segment_r_responder_outq.sv
// Three-entry output queue of {e, d} tokens; the head is gated so that
// e and d read as zero whenever the queue is empty.
module segment_r_outq
  import segment_pkg::*;
#(
  parameter int DW = SEG_DW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          push_e,
  input  logic [DW-1:0] push_d,
  input  logic          pop,
  output logic [1:0]    occ,
  output logic          head_v,
  output logic          head_e,
  output logic [DW-1:0] head_d
);

  logic [DW:0] slots [SEG_OUTQ_DEPTH];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      occ    <= 2'd0;
    end else begin
      if (push) wr_ptr <= seg_wrap_inc(wr_ptr);
      if (pop)  rd_ptr <= seg_wrap_inc(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Payload storage carries no reset; validity lives entirely in occ.
  always_ff @(posedge clock) begin
    if (push) slots[wr_ptr] <= {push_e, push_d};
  end

  always_comb begin
    head_v = (occ != 2'd0);
    head_e = 1'b0;
    head_d = '0;
    if (head_v) begin
      head_e = slots[rd_ptr][DW];
      head_d = slots[rd_ptr][DW-1:0];
    end
  end

endmodule

// File: rtl/segment_r_responder.sv
// Read-only segment responder: one data token per accepted address, in order,
// from a synchronous table RAM with a separate configuration write port.
module segment_r_responder
  import segment_pkg::*;
#(
  parameter int AW = SEG_AW,
  parameter int DW = SEG_DW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          segment_r_addr_e,
  input  logic          segment_r_addr_v,
  output logic          segment_r_addr_b,
  input  logic [AW-1:0] segment_r_addr_d,
  output logic          segment_r_data_e,
  output logic          segment_r_data_v,
  input  logic          segment_r_data_b,
  output logic [DW-1:0] segment_r_data_d,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [DW-1:0] cfg_wdata
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] table_mem [DEPTH];
  logic [DW-1:0] rd_data;
  logic          inflight;
  logic          stage_e;
  logic [1:0]    occ;
  logic          addr_accept;
  logic          data_pop;

  assign addr_accept = segment_r_addr_v && !segment_r_addr_b;
  assign data_pop    = segment_r_data_v && !segment_r_data_b;

  // Read and write share an edge, so a colliding read sees the old word.
  always_ff @(posedge clock) begin
    if (addr_accept && !segment_r_addr_e) rd_data <= table_mem[segment_r_addr_d];
    if (cfg_we) table_mem[cfg_addr] <= cfg_wdata;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inflight <= 1'b0;
      stage_e  <= 1'b0;
    end else begin
      inflight <= addr_accept;
      if (addr_accept) stage_e <= segment_r_addr_e;
    end
  end

  // Credit is derived from registers only, which also keeps the queue from overflowing.
  assign segment_r_addr_b = ({1'b0, occ} + {2'b00, inflight}) >= 3'(SEG_OUTQ_DEPTH);

  segment_r_outq #(.DW(DW)) u_outq (
    .clock  (clock),
    .reset  (reset),
    .push   (inflight),
    .push_e (stage_e),
    .push_d (stage_e ? '0 : rd_data),
    .pop    (data_pop),
    .occ    (occ),
    .head_v (segment_r_data_v),
    .head_e (segment_r_data_e),
    .head_d (segment_r_data_d)
  );

endmodule

// File: tb/tb_segment_r_responder.sv
// Directed bench for segment_r_responder with a table/queue scoreboard that
// follows every accepted address to its returned data token.
module tb_segment_r_responder;

  logic        clock;
  logic        reset;
  logic        addr_e;
  logic        addr_v;
  logic        addr_b;
  logic [7:0]  addr_d;
  logic        data_e;
  logic        data_v;
  logic        data_b;
  logic [15:0] data_d;
  logic        cfg_we;
  logic [7:0]  cfg_addr;
  logic [15:0] cfg_wdata;

  int checks = 0;
  int errors = 0;

  logic [15:0] model_mem [256];
  logic [16:0] exp_q [$];
  logic [16:0] got [$];

  segment_r_responder dut (
    .clock            (clock),
    .reset            (reset),
    .segment_r_addr_e (addr_e),
    .segment_r_addr_v (addr_v),
    .segment_r_addr_b (addr_b),
    .segment_r_addr_d (addr_d),
    .segment_r_data_e (data_e),
    .segment_r_data_v (data_v),
    .segment_r_data_b (data_b),
    .segment_r_data_d (data_d),
    .cfg_we           (cfg_we),
    .cfg_addr         (cfg_addr),
    .cfg_wdata        (cfg_wdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Presents one address token for a single cycle; the caller ensures credit.
  task automatic applyStimulus(input logic e, input logic [7:0] a);
    checkOutput("credit_free", {31'd0, addr_b}, 32'd0);
    addr_v = 1'b1;
    addr_e = e;
    addr_d = a;
    tick();
    addr_v = 1'b0;
    addr_e = 1'b0;
  endtask

  // Scoreboard: sampled on the falling edge, when all handshake inputs are settled.
  always @(negedge clock) begin
    if (!reset) begin
      exp_q.delete();
    end else begin
      checkOutput("outq_bounds", {31'd0, (32'(dut.u_outq.occ) + 32'(dut.inflight)) <= 32'd3}, 32'd1);
      checkOutput("outq_valid", {31'd0, data_v}, {31'd0, dut.u_outq.occ != 2'd0});
      if (data_v && !data_b) begin
        got.push_back({data_e, data_d});
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_token", {15'd0, data_e, data_d}, 32'h1ffff);
        end else begin
          checkOutput("scoreboard", {15'd0, data_e, data_d}, {15'd0, exp_q[0]});
          void'(exp_q.pop_front());
        end
      end
      if (addr_v && !addr_b) exp_q.push_back(addr_e ? 17'h10000 : {1'b0, model_mem[addr_d]});
    end
    if (cfg_we) model_mem[cfg_addr] = cfg_wdata;
  end

  initial begin
    int idx;
    int sent;
    int cyc;
    reset     = 1'b0;
    addr_e    = 1'b0;
    addr_v    = 1'b0;
    addr_d    = 8'd0;
    data_b    = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = 8'd0;
    cfg_wdata = 16'd0;

    #2;
    checkOutput("rst_data_v", {31'd0, data_v}, 32'd0);
    checkOutput("rst_data_e", {31'd0, data_e}, 32'd0);
    checkOutput("rst_data_d", {16'd0, data_d}, 32'd0);
    checkOutput("rst_addr_b", {31'd0, addr_b}, 32'd0);
    tick();
    tick();
    reset = 1'b1;

    $display("[TB] loading table[i] = i*3");
    for (int i = 0; i < 256; i++) begin
      cfg_we    = 1'b1;
      cfg_addr  = 8'(i);
      cfg_wdata = 16'(i * 3);
      tick();
    end
    cfg_we = 1'b0;

    $display("[TB] back-to-back reads 5, 6, 7");
    addr_v = 1'b1; addr_d = 8'd5;
    tick();
    checkOutput("b2b_not_yet", {31'd0, data_v}, 32'd0);
    addr_d = 8'd6;
    tick();
    checkOutput("b2b_lat_v", {31'd0, data_v}, 32'd1);
    checkOutput("b2b_d5", {16'd0, data_d}, 32'd15);
    checkOutput("b2b_credit", {31'd0, addr_b}, 32'd0);
    addr_d = 8'd7;
    tick();
    addr_v = 1'b0;
    checkOutput("b2b_d6", {16'd0, data_d}, 32'd18);
    checkOutput("b2b_credit2", {31'd0, addr_b}, 32'd0);
    tick();
    checkOutput("b2b_d7", {16'd0, data_d}, 32'd21);
    tick();
    checkOutput("b2b_idle", {31'd0, data_v}, 32'd0);

    $display("[TB] address 10 then EOS");
    applyStimulus(1'b0, 8'd10);
    applyStimulus(1'b1, 8'd77);
    checkOutput("eos_d10_v", {31'd0, data_v}, 32'd1);
    checkOutput("eos_d10_e", {31'd0, data_e}, 32'd0);
    checkOutput("eos_d10_d", {16'd0, data_d}, 32'd30);
    tick();
    checkOutput("eos_tok_v", {31'd0, data_v}, 32'd1);
    checkOutput("eos_tok_e", {31'd0, data_e}, 32'd1);
    checkOutput("eos_tok_d", {16'd0, data_d}, 32'd0);
    tick();
    checkOutput("eos_idle", {31'd0, data_v}, 32'd0);

    $display("[TB] stall with five offered addresses");
    got.delete();
    data_b = 1'b1;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      logic acc;
      addr_v = 1'b1;
      addr_d = 8'(20 + idx);
      acc = !addr_b;
      tick();
      if (acc) idx++;
    end
    checkOutput("stall_accepted", idx, 32'd3);
    checkOutput("stall_addr_b", {31'd0, addr_b}, 32'd1);
    checkOutput("stall_head_d", {16'd0, data_d}, 32'd60);
    tick();
    checkOutput("stall_hold_v", {31'd0, data_v}, 32'd1);
    checkOutput("stall_hold_e", {31'd0, data_e}, 32'd0);
    checkOutput("stall_hold_d", {16'd0, data_d}, 32'd60);
    data_b = 1'b0;
    cyc = 0;
    while (idx < 5 && cyc < 50) begin
      logic acc;
      addr_v = 1'b1;
      addr_d = 8'(20 + idx);
      acc = !addr_b;
      tick();
      if (acc) idx++;
      cyc++;
    end
    addr_v = 1'b0;
    cyc = 0;
    while (got.size() < 5 && cyc < 50) begin
      tick();
      cyc++;
    end
    checkOutput("stall_count", got.size(), 32'd5);
    for (int k = 0; k < 5; k++) begin
      logic [16:0] g;
      g = (k < got.size()) ? got[k] : 17'h1ffff;
      checkOutput($sformatf("stall_order%0d", k), {15'd0, g}, 32'((20 + k) * 3));
    end

    $display("[TB] read-before-write collision at address 9");
    cfg_we    = 1'b1;
    cfg_addr  = 8'd9;
    cfg_wdata = 16'hBEEF;
    applyStimulus(1'b0, 8'd9);
    cfg_we = 1'b0;
    tick();
    checkOutput("rbw_old_v", {31'd0, data_v}, 32'd1);
    checkOutput("rbw_old_d", {16'd0, data_d}, 32'd27);
    tick();
    applyStimulus(1'b0, 8'd9);
    tick();
    checkOutput("rbw_new_d", {16'd0, data_d}, 32'hBEEF);
    tick();

    $display("[TB] random backpressure over 200 tokens");
    got.delete();
    sent = 0;
    cyc  = 0;
    while (sent < 200 && cyc < 5000) begin
      addr_v = ($urandom_range(0, 3) != 0);
      addr_e = ($urandom_range(0, 7) == 0);
      addr_d = 8'($urandom_range(0, 255));
      data_b = ($urandom_range(0, 2) == 0);
      if (addr_v && !addr_b) sent++;
      tick();
      cyc++;
    end
    addr_v = 1'b0;
    addr_e = 1'b0;
    data_b = 1'b0;
    checkOutput("rand_sent", sent, 32'd200);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      tick();
      cyc++;
    end
    checkOutput("rand_drained", exp_q.size(), 32'd0);
    checkOutput("rand_count", got.size(), 32'd200);

    $display("[TB] reset with two tokens queued");
    data_b = 1'b1;
    applyStimulus(1'b0, 8'd1);
    applyStimulus(1'b0, 8'd2);
    tick();
    tick();
    checkOutput("prerst_v", {31'd0, data_v}, 32'd1);
    checkOutput("prerst_d", {16'd0, data_d}, 32'd3);
    #3;
    reset = 1'b0;
    #1;
    checkOutput("async_rst_v", {31'd0, data_v}, 32'd0);
    checkOutput("async_rst_d", {16'd0, data_d}, 32'd0);
    checkOutput("async_rst_b", {31'd0, addr_b}, 32'd0);
    tick();
    tick();
    reset  = 1'b1;
    data_b = 1'b0;
    got.delete();
    for (int c = 0; c < 4; c++) begin
      checkOutput("postrst_no_stale", {31'd0, data_v}, 32'd0);
      checkOutput("postrst_addr_b", {31'd0, addr_b}, 32'd0);
      tick();
    end
    checkOutput("postrst_got", got.size(), 32'd0);
    applyStimulus(1'b0, 8'd100);
    tick();
    checkOutput("retain_d100", {16'd0, data_d}, 32'd300);
    tick();
    applyStimulus(1'b0, 8'd9);
    tick();
    checkOutput("retain_d9", {16'd0, data_d}, 32'hBEEF);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
